// File: rtl/scanline_gen_pkg.sv
// Shared definitions for the scanline generator: config field positions,
// pipeline latency, shadow-config and timing-bundle types.
package scanline_gen_pkg;

  localparam int unsigned SL_LATENCY = 3;

  // sl_config fields
  localparam int unsigned L_MASK_LSB  = 0;
  localparam int unsigned L_PER_LSB   = 16;
  localparam int unsigned L_PHASE_LSB = 20;
  localparam int unsigned STR_LSB     = 24;
  // sl_config2 fields
  localparam int unsigned C_MASK_LSB  = 0;
  localparam int unsigned C_PER_LSB   = 16;
  localparam int unsigned ENABLE_BIT  = 20;

  typedef struct packed {
    logic [15:0] l_mask;
    logic [3:0]  l_per_m1;
    logic [3:0]  l_phase;
    logic [3:0]  str;
    logic [15:0] c_mask;
    logic [3:0]  c_per_m1;
    logic        enable;
  } sl_cfg_t;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] xpos;
    logic [10:0] ypos;
  } sl_timing_t;

  localparam sl_timing_t TIMING_RESET = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0,
                                          xpos: 12'd0, ypos: 11'd0};

  // Advance a phase counter, wrapping after per_m1 (also recovers from cur > per_m1).
  function automatic logic [3:0] phase_step(input logic [3:0] cur, input logic [3:0] per_m1);
    return (cur >= per_m1) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/scanline_gen_sl_atten.sv
// One colour channel scaled by (16 - STR)/16, result registered.
module sl_atten (
  input  logic       PCLK_i,
  input  logic       reset_i,
  input  logic [7:0] pix_i,
  input  logic [3:0] str_i,
  output logic [7:0] pix_o
);

  logic [4:0]  gain;
  logic [12:0] prod;
  logic [8:0]  scaled;

  always_comb begin
    gain   = 5'd16 - {1'b0, str_i};
    prod   = {5'd0, pix_i} * {8'd0, gain};
    scaled = prod[12:4];
  end

  // scaled[8] can never be set (255*16 < 4096); the clamp only keeps every product bit in use.
  always_ff @(posedge PCLK_i) begin
    if (reset_i) pix_o <= '0;
    else         pix_o <= scaled[8] ? 8'hFF : scaled[7:0];
  end

endmodule

// File: rtl/scanline_gen.sv
// Scanline overlay: 3-stage pipeline that attenuates selected lines/columns
// of the pixel stream, with config shadowed at each VSYNC falling edge.
module scanline_gen
  import scanline_gen_pkg::*;
(
  input  logic        PCLK_i,
  input  logic        reset_i,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  input  logic        HSYNC_i,
  input  logic        VSYNC_i,
  input  logic        DE_i,
  input  logic [11:0] xpos_i,
  input  logic [10:0] ypos_i,
  input  logic [31:0] sl_config,
  input  logic [31:0] sl_config2,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        DE_o,
  output logic [11:0] xpos_o,
  output logic [10:0] ypos_o
);

  sl_cfg_t    cfg_sh, cfg_in;
  logic       vsync_prev;
  logic [3:0] lphase, cphase, lphase_nxt, cphase_nxt;
  logic       sl_flag;
  sl_timing_t tin, t1, t2;
  logic [23:0] rgb1, rgb2;
  logic       flag1, flag2;
  logic [3:0] str1;
  logic [7:0] r_att, g_att, b_att;
  logic       unused_cfg_bits;

  assign unused_cfg_bits = &{1'b0, sl_config[31:28], sl_config2[31:21]};

  always_comb begin
    cfg_in = '{l_mask:   sl_config[L_MASK_LSB +: 16],
               l_per_m1: sl_config[L_PER_LSB +: 4],
               l_phase:  sl_config[L_PHASE_LSB +: 4],
               str:      sl_config[STR_LSB +: 4],
               c_mask:   sl_config2[C_MASK_LSB +: 16],
               c_per_m1: sl_config2[C_PER_LSB +: 4],
               enable:   sl_config2[ENABLE_BIT]};
    tin = '{hsync: HSYNC_i, vsync: VSYNC_i, de: DE_i, xpos: xpos_i, ypos: ypos_i};
  end

  // Phases are resolved combinationally so the pixel uses the value that applies to it.
  always_comb begin
    lphase_nxt = lphase;
    cphase_nxt = cphase;
    if (DE_i) begin
      if (xpos_i == '0) begin
        cphase_nxt = '0;
        if (ypos_i == '0)
          lphase_nxt = (cfg_sh.l_phase > cfg_sh.l_per_m1) ? cfg_sh.l_per_m1 : cfg_sh.l_phase;
        else
          lphase_nxt = phase_step(lphase, cfg_sh.l_per_m1);
      end else begin
        cphase_nxt = phase_step(cphase, cfg_sh.c_per_m1);
      end
    end
    sl_flag = cfg_sh.enable & (cfg_sh.l_mask[lphase_nxt] | cfg_sh.c_mask[cphase_nxt]);
  end

  always_ff @(posedge PCLK_i) begin
    if (reset_i) begin
      cfg_sh     <= '0;
      vsync_prev <= 1'b0;
      lphase     <= '0;
      cphase     <= '0;
    end else begin
      vsync_prev <= VSYNC_i;
      if (vsync_prev && !VSYNC_i) cfg_sh <= cfg_in;
      lphase <= lphase_nxt;
      cphase <= cphase_nxt;
    end
  end

  sl_atten u_atten_r (.PCLK_i(PCLK_i), .reset_i(reset_i), .pix_i(rgb1[23:16]), .str_i(str1), .pix_o(r_att));
  sl_atten u_atten_g (.PCLK_i(PCLK_i), .reset_i(reset_i), .pix_i(rgb1[15:8]),  .str_i(str1), .pix_o(g_att));
  sl_atten u_atten_b (.PCLK_i(PCLK_i), .reset_i(reset_i), .pix_i(rgb1[7:0]),   .str_i(str1), .pix_o(b_att));

  always_ff @(posedge PCLK_i) begin
    if (reset_i) begin
      t1      <= TIMING_RESET;
      t2      <= TIMING_RESET;
      rgb1    <= '0;
      rgb2    <= '0;
      flag1   <= 1'b0;
      flag2   <= 1'b0;
      str1    <= '0;
      R_o     <= '0;
      G_o     <= '0;
      B_o     <= '0;
      HSYNC_o <= 1'b1;
      VSYNC_o <= 1'b1;
      DE_o    <= 1'b0;
      xpos_o  <= '0;
      ypos_o  <= '0;
    end else begin
      t1    <= tin;
      rgb1  <= {R_i, G_i, B_i};
      flag1 <= sl_flag;
      str1  <= cfg_sh.str;
      t2    <= t1;
      rgb2  <= rgb1;
      flag2 <= flag1;
      HSYNC_o <= t2.hsync;
      VSYNC_o <= t2.vsync;
      DE_o    <= t2.de;
      xpos_o  <= t2.xpos;
      ypos_o  <= t2.ypos;
      if (!t2.de)     {R_o, G_o, B_o} <= '0;
      else if (flag2) {R_o, G_o, B_o} <= {r_att, g_att, b_att};
      else            {R_o, G_o, B_o} <= rgb2;
    end
  end

endmodule
